// File: rtl/psram_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : psram_spi_responder
// Purpose  : Device-side SPI-mode PSRAM model. Decodes the host's serial
//            command stream (reset-enable/reset, write, read, read-ID and,
//            optionally, fast read) and backs it with an internal byte array.
// Ports    : mem_clk    - serial clock; sample on posedge, drive on negedge
//            sys_rst_n  - asynchronous active-low reset
//            mem_ce_n   - chip enable, active low
//            mem_si     - serial data in, MSB first
//            mem_so     - serial data out, MSB first
//            mem_so_oe  - high while mem_so carries read/ID data
//            rst_done   - one-cycle pulse when 0x66 then 0x99 is accepted
//            cmd_err    - one-cycle pulse on an unsupported opcode
// Config   : define PSRAM_FAST_READ_EN to accept opcode 0x0B (8 dummy clocks).
// Notes    : ADDR_W must not exceed 24. Array contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module psram_spi_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter logic [7:0]  MFID   = 8'h0D,
  parameter logic [7:0]  KGD    = 8'h5D
) (
  input  logic mem_clk,
  input  logic sys_rst_n,
  input  logic mem_ce_n,
  input  logic mem_si,
  output logic mem_so,
  output logic mem_so_oe,
  output logic rst_done,
  output logic cmd_err
);

  // Shift register only needs to hold the widest field actually consumed:
  // the low ADDR_W address bits or an 8-bit opcode/data byte.
  localparam int unsigned SR_W  = (ADDR_W > 8) ? ADDR_W : 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [7:0] OP_RST_EN  = 8'h66;
  localparam logic [7:0] OP_RST     = 8'h99;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_READ_ID = 8'h9F;
`ifdef PSRAM_FAST_READ_EN
  localparam logic [7:0] OP_FAST_RD = 8'h0B;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_WDATA  = 3'd4;
  localparam logic [2:0] S_RDATA  = 3'd5;
  localparam logic [2:0] S_IDOUT  = 3'd6;
  localparam logic [2:0] S_IGNORE = 3'd7;

  logic [2:0]        state_q,    state_d;
  logic [4:0]        bit_cnt_q,  bit_cnt_d;
  logic [SR_W-2:0]   sr_q,       sr_d;
  logic [7:0]        op_q,       op_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              rst_en_q,   rst_en_d;
  logic              id_sel_q,   id_sel_d;
  logic              rst_done_q, rst_done_d;
  logic              cmd_err_q,  cmd_err_d;
  logic              so_q,       oe_q;

  logic [SR_W-1:0]   sr_shift;
  logic              wr_en;
  logic [7:0]        out_byte;

  logic [7:0]        mem_q [DEPTH];

  // Shift register view including the bit sampled on this posedge.
  assign sr_shift = {sr_q, mem_si};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rst_en_d   = rst_en_q;
    id_sel_d   = id_sel_q;
    rst_done_d = 1'b0;
    cmd_err_d  = 1'b0;
    wr_en      = 1'b0;

    if (mem_ce_n) begin
      // Deselect aborts anything in flight; a partial write byte is dropped.
      state_d   = S_IDLE;
      bit_cnt_d = 5'd0;
    end else begin
      case (state_q)
        // The first selected posedge already carries opcode bit 7.
        S_IDLE, S_CMD: begin
          sr_d = sr_shift[SR_W-2:0];
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            op_d      = sr_shift[7:0];
            rst_en_d  = 1'b0;
            state_d   = S_IGNORE;
            case (sr_shift[7:0])
              OP_RST_EN:  rst_en_d   = 1'b1;
              OP_RST:     rst_done_d = rst_en_q;
              OP_WRITE,
              OP_READ,
              OP_READ_ID: state_d    = S_ADDR;
`ifdef PSRAM_FAST_READ_EN
              OP_FAST_RD: state_d    = S_ADDR;
`endif
              default:    cmd_err_d  = 1'b1;
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = S_CMD;
          end
        end

        S_ADDR: begin
          sr_d = sr_shift[SR_W-2:0];
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = 5'd0;
            addr_d    = sr_shift[ADDR_W-1:0];
            id_sel_d  = 1'b0;
            case (op_q)
              OP_WRITE:   state_d = S_WDATA;
              OP_READ:    state_d = S_RDATA;
              OP_READ_ID: state_d = S_IDOUT;
`ifdef PSRAM_FAST_READ_EN
              OP_FAST_RD: state_d = S_DUMMY;
`endif
              default:    state_d = S_IGNORE;
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end

        S_DUMMY: begin
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            state_d   = S_RDATA;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end

        S_WDATA: begin
          sr_d = sr_shift[SR_W-2:0];
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            wr_en     = 1'b1;
            addr_d    = addr_q + ADDR_W'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end

        S_RDATA: begin
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            addr_d    = addr_q + ADDR_W'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end

        S_IDOUT: begin
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            id_sel_d  = ~id_sel_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end

        default: ;  // S_IGNORE: consume clocks until deselect
      endcase
    end
  end

  always_ff @(posedge mem_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 5'd0;
      sr_q       <= '0;
      op_q       <= 8'h00;
      addr_q     <= '0;
      rst_en_q   <= 1'b0;
      id_sel_q   <= 1'b0;
      rst_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      rst_en_q   <= rst_en_d;
      id_sel_q   <= id_sel_d;
      rst_done_q <= rst_done_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge mem_clk) begin
    if (wr_en) begin
      mem_q[addr_q] <= sr_shift[7:0];
    end
  end

  // Output byte is read asynchronously so the first bit can go out on the
  // negedge right after the final address (or dummy) posedge.
  assign out_byte = (state_q == S_IDOUT) ? (id_sel_q ? KGD : MFID) : mem_q[addr_q];

  always_ff @(negedge mem_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      so_q <= 1'b0;
      oe_q <= 1'b0;
    end else if ((state_q == S_RDATA) || (state_q == S_IDOUT)) begin
      so_q <= out_byte[~bit_cnt_q[2:0]];
      oe_q <= 1'b1;
    end else begin
      so_q <= 1'b0;
      oe_q <= 1'b0;
    end
  end

  assign mem_so    = so_q;
  assign mem_so_oe = oe_q;
  assign rst_done  = rst_done_q;
  assign cmd_err   = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_psram_spi_responder
// Purpose  : Self-checking bench for psram_spi_responder. A table of host
//            transactions is replayed; read data is predicted into a queue
//            when the read is issued and compared as bytes come back.
//            Hand-written sequences cover reset mid-read and aborted writes.
// Config   : PSRAM_FAST_READ_EN selects the expected 0x0B behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psram_spi_responder;

  localparam int ADDR_W = 10;

  logic mem_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic mem_ce_n  = 1'b1;
  logic mem_si    = 1'b0;
  logic mem_so, mem_so_oe, rst_done, cmd_err;

  always #5 mem_clk = ~mem_clk;

  psram_spi_responder #(
    .ADDR_W (ADDR_W),
    .MFID   (8'h0D),
    .KGD    (8'h5D)
  ) dut (
    .mem_clk   (mem_clk),
    .sys_rst_n (sys_rst_n),
    .mem_ce_n  (mem_ce_n),
    .mem_si    (mem_si),
    .mem_so    (mem_so),
    .mem_so_oe (mem_so_oe),
    .rst_done  (rst_done),
    .cmd_err   (cmd_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rst_done_cnt = 0;
  int cmd_err_cnt  = 0;

  // A one-cycle pulse spans exactly one negedge.
  always @(negedge mem_clk) begin
    if (rst_done === 1'b1) rst_done_cnt++;
    if (cmd_err  === 1'b1) cmd_err_cnt++;
  end

  typedef enum logic [1:0] {K_WR, K_RD, K_IGN} kind_e;
  typedef struct {
    logic [7:0]  op;
    kind_e       kind;
    logic [23:0] addr;
    int          n;
    logic [31:0] data;
    int          exp_rd;
    int          exp_ce;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx,
                           output logic oe_and, output logic oe_or);
    oe_and = 1'b1;
    oe_or  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge mem_clk);
      mem_ce_n = 1'b0;
      mem_si   = tx[i];
      @(posedge mem_clk);
      #1;
      rx[i]  = mem_so;
      oe_and = oe_and & mem_so_oe;
      oe_or  = oe_or | mem_so_oe;
    end
  endtask

  task automatic end_txn();
    @(negedge mem_clk);
    mem_ce_n = 1'b1;
    mem_si   = 1'b0;
    @(posedge mem_clk);
    @(negedge mem_clk);
    #1;
    check("oe_after_deselect", {31'd0, mem_so_oe}, 32'd0);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr, output logic oe_seen);
    logic [7:0] rx;
    logic a, o;
    xfer_byte(op, rx, a, o);
    oe_seen = o;
    for (int j = 2; j >= 0; j--) begin
      xfer_byte(addr[j*8 +: 8], rx, a, o);
      oe_seen = oe_seen | o;
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [7:0] rx, d, exp;
    logic a, o, oe_pre;
    int rd0, ce0;
    rd0 = rst_done_cnt;
    ce0 = cmd_err_cnt;
    if (v.kind == K_IGN) begin
      xfer_byte(v.op, rx, a, oe_pre);
      xfer_byte(8'h00, rx, a, o);
      oe_pre = oe_pre | o;
    end else begin
      send_hdr(v.op, v.addr, oe_pre);
      if (v.op == 8'h0B) begin
        xfer_byte(8'h00, rx, a, o);  // dummy clocks
        oe_pre = oe_pre | o;
      end
      for (int b = 0; b < v.n; b++) begin
        d = v.data[31 - 8*b -: 8];
        if (v.kind == K_WR) begin
          xfer_byte(d, rx, a, o);
          oe_pre = oe_pre | o;
        end else begin
          sb_q.push_back(d);
          xfer_byte(8'hFF, rx, a, o);
          exp = sb_q.pop_front();
          check($sformatf("rd op%h byte%0d", v.op, b), {24'd0, rx}, {24'd0, exp});
          check("oe_during_data", {31'd0, a}, 32'd1);
        end
      end
    end
    end_txn();
    check($sformatf("oe_idle op%h", v.op), {31'd0, oe_pre}, 32'd0);
    check($sformatf("rst_done op%h", v.op), rst_done_cnt - rd0, v.exp_rd);
    check($sformatf("cmd_err op%h", v.op), cmd_err_cnt - ce0, v.exp_ce);
  endtask

  // Write one full byte, then deselect after nbits of the second byte.
  task automatic abort_write(input logic [23:0] addr, input int nbits);
    logic [7:0] rx, second;
    logic a, o, oe_pre;
    second = 8'h88;
    send_hdr(8'h02, addr, oe_pre);
    xfer_byte(8'h77, rx, a, o);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge mem_clk);
      mem_ce_n = 1'b0;
      mem_si   = second[i];
      @(posedge mem_clk);
    end
    end_txn();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic oe_pre;
    logic [7:0] rx;
    logic a, o;

    vecs.push_back('{8'h02, K_WR,  24'h000005, 2, 32'hA53C0000, 0, 0});
    vecs.push_back('{8'h03, K_RD,  24'h000005, 2, 32'hA53C0000, 0, 0});
    vecs.push_back('{8'h02, K_WR,  24'h0003FF, 2, 32'h11220000, 0, 0});
    vecs.push_back('{8'h03, K_RD,  24'h0003FF, 2, 32'h11220000, 0, 0});
    vecs.push_back('{8'h03, K_RD,  24'h000000, 1, 32'h22000000, 0, 0});
    vecs.push_back('{8'h03, K_RD,  24'hFFFC05, 1, 32'hA5000000, 0, 0});
    vecs.push_back('{8'h9F, K_RD,  24'h000000, 4, 32'h0D5D0D5D, 0, 0});
    vecs.push_back('{8'h55, K_IGN, 24'h000000, 0, 32'h0,        0, 1});
    vecs.push_back('{8'h66, K_IGN, 24'h000000, 0, 32'h0,        0, 0});
    vecs.push_back('{8'h99, K_IGN, 24'h000000, 0, 32'h0,        1, 0});
    vecs.push_back('{8'h99, K_IGN, 24'h000000, 0, 32'h0,        0, 0});
    vecs.push_back('{8'h66, K_IGN, 24'h000000, 0, 32'h0,        0, 0});
    vecs.push_back('{8'h9F, K_RD,  24'h000000, 1, 32'h0D000000, 0, 0});
    vecs.push_back('{8'h99, K_IGN, 24'h000000, 0, 32'h0,        0, 0});
`ifdef PSRAM_FAST_READ_EN
    vecs.push_back('{8'h0B, K_RD,  24'h000005, 2, 32'hA53C0000, 0, 0});
`else
    vecs.push_back('{8'h0B, K_IGN, 24'h000000, 0, 32'h0,        0, 1});
`endif
    vecs.push_back('{8'h02, K_WR,  24'h000011, 1, 32'hEE000000, 0, 0});
    vecs.push_back('{8'h02, K_WR,  24'h000021, 1, 32'hDD000000, 0, 0});

    // Reset state
    repeat (3) @(posedge mem_clk);
    #1;
    check("reset_outputs", {28'd0, mem_so, mem_so_oe, rst_done, cmd_err}, 32'd0);
    @(negedge mem_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge mem_clk);

    foreach (vecs[k]) run_txn(vecs[k]);

    // Aborted writes: after 5 bits, and on the posedge that would finish the byte.
    abort_write(24'h000010, 5);
    run_txn('{8'h03, K_RD, 24'h000010, 2, 32'h77EE0000, 0, 0});
    abort_write(24'h000020, 7);
    run_txn('{8'h03, K_RD, 24'h000020, 2, 32'h77DD0000, 0, 0});

    // Reset in the middle of a read, then a normal read.
    send_hdr(8'h03, 24'h000005, oe_pre);
    for (int i = 0; i < 4; i++) begin
      @(negedge mem_clk);
      @(posedge mem_clk);
    end
    #1;
    check("oe_before_reset", {31'd0, mem_so_oe}, 32'd1);
    #2;
    sys_rst_n = 1'b0;
    mem_ce_n  = 1'b1;
    #1;
    check("async_reset_outputs", {28'd0, mem_so, mem_so_oe, rst_done, cmd_err}, 32'd0);
    repeat (2) @(posedge mem_clk);
    @(negedge mem_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge mem_clk);
    run_txn('{8'h03, K_RD, 24'h000005, 2, 32'hA53C0000, 0, 0});

    xfer_byte(8'h00, rx, a, o);  // keep loop vars referenced
    end_txn();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
